// File: rtl/vxc_chunk_sequencer.sv
// vxc_chunk_sequencer
// Runs one vector-times-constant add/subtract pass (r = y +/- c*x) over NOE
// elements. The pass is cut into NCH = ceil(NOE/NI) chunks. One chunk word is
// read per cycle from the x and y row memories. Each issued chunk is followed
// through the fixed read + datapath latency, so the result write-back for that
// chunk lands on the correct cycle with the correct lane mask.
//
// Optional build macro: VXC_SEQ_STALL_EN
//   When it is defined, the block has an extra `stall` input. While stall is
//   high in ISSUE, the read and the tracker push are held off. Chunks already
//   in flight still drain on schedule.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   start               request a pass (sampled only in IDLE)
//   op_in, constant_in  add(0)/subtract(1) and scalar c, latched on accepted start
//   x_base, y_base,     row base word addresses, latched on accepted start
//   r_base
//   stall               (VXC_SEQ_STALL_EN only) hold chunk issue
//   rd_en, x_rd_addr,   operand read strobe and word addresses
//   y_rd_addr
//   dp_op, dp_constant  latched op/constant driven to the datapath
//   wr_en, wr_addr,     result write strobe, word address, per-lane enable
//   wr_mask
//   busy, finish        pass in progress / pass complete (sticky until next start)

module vxc_chunk_sequencer #(
  parameter int NOE           = 19,
  parameter int NI            = 8,
  parameter int ELEMENT_WIDTH = 64,
  parameter int ADDR_WIDTH    = 8,
  parameter int RD_LAT        = 1,
  parameter int PIPE_LAT      = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     op_in,
  input  logic [ELEMENT_WIDTH-1:0] constant_in,
  input  logic [ADDR_WIDTH-1:0]    x_base,
  input  logic [ADDR_WIDTH-1:0]    y_base,
  input  logic [ADDR_WIDTH-1:0]    r_base,
`ifdef VXC_SEQ_STALL_EN
  input  logic                     stall,
`endif
  output logic                     rd_en,
  output logic [ADDR_WIDTH-1:0]    x_rd_addr,
  output logic [ADDR_WIDTH-1:0]    y_rd_addr,
  output logic                     dp_op,
  output logic [ELEMENT_WIDTH-1:0] dp_constant,
  output logic                     wr_en,
  output logic [ADDR_WIDTH-1:0]    wr_addr,
  output logic [NI-1:0]            wr_mask,
  output logic                     busy,
  output logic                     finish
);

  localparam int NCH   = (NOE + NI - 1) / NI;
  localparam int DEPTH = RD_LAT + PIPE_LAT;
  localparam int IW    = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int REM   = NOE % NI;

  localparam logic [NI-1:0] FULL_MASK = {NI{1'b1}};
  // Element 0 of a chunk sits in the most-significant lane. A partial last
  // chunk therefore keeps its top REM lanes.
  localparam logic [NI-1:0] LAST_MASK = (REM == 0) ? FULL_MASK : ~(FULL_MASK >> REM);
  localparam logic [IW-1:0] LAST_IDX  = IW'(NCH - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t                   state_reg, state_next;
  logic [IW-1:0]            chunk_reg;
  logic                     op_reg;
  logic [ELEMENT_WIDTH-1:0] constant_reg;
  logic [ADDR_WIDTH-1:0]    x_base_reg, y_base_reg, r_base_reg;
  logic                     finish_reg;

  // In-flight tracker: one valid bit per stage, plus the chunk index in that stage.
  logic [DEPTH-1:0]         trk_valid_reg;
  logic [DEPTH-1:0]         trk_valid_next;
  logic [IW-1:0]            trk_idx_reg [DEPTH];

  logic                     stall_w;
  logic                     issue_fire;
  logic                     accept;

`ifdef VXC_SEQ_STALL_EN
  assign stall_w = stall;
`else
  assign stall_w = 1'b0;
`endif

  assign accept = (state_reg == IDLE) && start;

  // Tracker contents after the shift at the coming edge. In DRAIN nothing new
  // is pushed, so a zero here means the current wr_en is the last one.
  assign trk_valid_next = (trk_valid_reg << 1) | DEPTH'(issue_fire);

  // ---------------- state register ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = ISSUE;
      ISSUE:   if (issue_fire && (chunk_reg == LAST_IDX)) state_next = DRAIN;
      DRAIN:   if ((trk_valid_reg << 1) == '0) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------- output logic ----------------
  always_comb begin
    busy       = 1'b0;
    issue_fire = 1'b0;
    case (state_reg)
      ISSUE: begin
        busy       = 1'b1;
        issue_fire = !stall_w;
      end
      DRAIN:   busy = 1'b1;
      default: ;
    endcase

    rd_en     = issue_fire;
    x_rd_addr = '0;
    y_rd_addr = '0;
    if (issue_fire) begin
      x_rd_addr = x_base_reg + ADDR_WIDTH'(chunk_reg);
      y_rd_addr = y_base_reg + ADDR_WIDTH'(chunk_reg);
    end

    wr_en   = trk_valid_reg[DEPTH-1];
    wr_addr = '0;
    wr_mask = '0;
    if (trk_valid_reg[DEPTH-1]) begin
      wr_addr = r_base_reg + ADDR_WIDTH'(trk_idx_reg[DEPTH-1]);
      wr_mask = (trk_idx_reg[DEPTH-1] == LAST_IDX) ? LAST_MASK : FULL_MASK;
    end
  end

  assign dp_op       = op_reg;
  assign dp_constant = constant_reg;
  assign finish      = finish_reg;

  // ---------------- pass context and chunk counter ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      op_reg       <= 1'b0;
      constant_reg <= '0;
      x_base_reg   <= '0;
      y_base_reg   <= '0;
      r_base_reg   <= '0;
      chunk_reg    <= '0;
      finish_reg   <= 1'b0;
    end else begin
      if (accept) begin
        op_reg       <= op_in;
        constant_reg <= constant_in;
        x_base_reg   <= x_base;
        y_base_reg   <= y_base;
        r_base_reg   <= r_base;
        chunk_reg    <= '0;
        finish_reg   <= 1'b0;
      end else if (issue_fire) begin
        chunk_reg <= chunk_reg + IW'(1);
      end
      // finish is sticky through IDLE until the next accepted start.
      if (state_next == DONE) begin
        finish_reg <= 1'b1;
      end
    end
  end

  // ---------------- in-flight tracker ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      trk_valid_reg <= '0;
    end else begin
      trk_valid_reg <= trk_valid_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      trk_idx_reg[0] <= '0;
    end else begin
      trk_idx_reg[0] <= chunk_reg;
    end
  end

  generate
    for (genvar gi = 1; gi < DEPTH; gi++) begin : g_trk_stage
      always_ff @(posedge clk) begin
        if (reset) begin
          trk_idx_reg[gi] <= '0;
        end else begin
          trk_idx_reg[gi] <= trk_idx_reg[gi-1];
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_vxc_chunk_sequencer.sv
module tb_vxc_chunk_sequencer;

  localparam logic [63:0] C2  = 64'h4000_0000_0000_0000;  // 2.0
  localparam logic [63:0] C15 = 64'h3FF8_0000_0000_0000;  // 1.5

  logic        clk = 1'b0;
  logic        reset, start, start16, op_in;
  logic [63:0] constant_in;
  logic [7:0]  x_base, y_base, r_base;
`ifdef VXC_SEQ_STALL_EN
  logic        stall;
`endif

  logic        rd_en, dp_op, wr_en, busy, finish;
  logic [7:0]  x_rd_addr, y_rd_addr, wr_addr, wr_mask;
  logic [63:0] dp_constant;

  logic        rd_en_16, dp_op_16, wr_en_16, busy_16, finish_16;
  logic [7:0]  x_rd_addr_16, y_rd_addr_16, wr_addr_16, wr_mask_16;
  logic [63:0] dp_constant_16;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  typedef struct {
    int         cyc;
    logic [7:0] a0;
    logic [7:0] a1;
    logic [7:0] m;
  } ev_t;

  ev_t rd_q[$], wr_q[$], rd16_q[$], wr16_q[$];
  ev_t mon_ev;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  vxc_chunk_sequencer #(.NOE(19)) dut (
    .clk(clk), .reset(reset), .start(start), .op_in(op_in),
    .constant_in(constant_in), .x_base(x_base), .y_base(y_base), .r_base(r_base),
`ifdef VXC_SEQ_STALL_EN
    .stall(stall),
`endif
    .rd_en(rd_en), .x_rd_addr(x_rd_addr), .y_rd_addr(y_rd_addr),
    .dp_op(dp_op), .dp_constant(dp_constant),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_mask(wr_mask),
    .busy(busy), .finish(finish)
  );

  vxc_chunk_sequencer #(.NOE(16)) dut16 (
    .clk(clk), .reset(reset), .start(start16), .op_in(op_in),
    .constant_in(constant_in), .x_base(x_base), .y_base(y_base), .r_base(r_base),
`ifdef VXC_SEQ_STALL_EN
    .stall(stall),
`endif
    .rd_en(rd_en_16), .x_rd_addr(x_rd_addr_16), .y_rd_addr(y_rd_addr_16),
    .dp_op(dp_op_16), .dp_constant(dp_constant_16),
    .wr_en(wr_en_16), .wr_addr(wr_addr_16), .wr_mask(wr_mask_16),
    .busy(busy_16), .finish(finish_16)
  );

  // Scoreboard monitor: every read/write beat is popped and compared against the
  // expectation queued when the pass was started. A missing beat is detected
  // once its expected cycle has gone by.
  always @(negedge clk) begin
    // ---- NOE=19 reads ----
    if (rd_en) begin
      compared++;
      if (rd_q.size() == 0) begin
        mismatched++;
        $display("FAIL rd_unexpected: cycle %0d rd_en=1 x=%h, required rd_en=0", cyc, x_rd_addr);
      end else begin
        mon_ev = rd_q.pop_front();
        $display("rd  cycle %0d x=%h y=%h", cyc, x_rd_addr, y_rd_addr);
        if (mon_ev.cyc != cyc || x_rd_addr !== mon_ev.a0 || y_rd_addr !== mon_ev.a1) begin
          mismatched++;
          $display("FAIL rd_beat: cycle %0d x=%h y=%h, required cycle %0d x=%h y=%h",
                   cyc, x_rd_addr, y_rd_addr, mon_ev.cyc, mon_ev.a0, mon_ev.a1);
        end
      end
    end else if (rd_q.size() != 0 && rd_q[0].cyc <= cyc) begin
      compared++;
      mismatched++;
      mon_ev = rd_q.pop_front();
      $display("FAIL rd_missing: cycle %0d rd_en=0, required rd_en=1 x=%h", cyc, mon_ev.a0);
    end
    // ---- NOE=19 writes ----
    if (wr_en) begin
      compared++;
      if (wr_q.size() == 0) begin
        mismatched++;
        $display("FAIL wr_unexpected: cycle %0d wr_en=1 addr=%h, required wr_en=0", cyc, wr_addr);
      end else begin
        mon_ev = wr_q.pop_front();
        $display("wr  cycle %0d addr=%h mask=%h", cyc, wr_addr, wr_mask);
        if (mon_ev.cyc != cyc || wr_addr !== mon_ev.a0 || wr_mask !== mon_ev.m) begin
          mismatched++;
          $display("FAIL wr_beat: cycle %0d addr=%h mask=%h, required cycle %0d addr=%h mask=%h",
                   cyc, wr_addr, wr_mask, mon_ev.cyc, mon_ev.a0, mon_ev.m);
        end
      end
    end else if (wr_q.size() != 0 && wr_q[0].cyc <= cyc) begin
      compared++;
      mismatched++;
      mon_ev = wr_q.pop_front();
      $display("FAIL wr_missing: cycle %0d wr_en=0, required wr_en=1 addr=%h", cyc, mon_ev.a0);
    end
    // ---- NOE=16 reads ----
    if (rd_en_16) begin
      compared++;
      if (rd16_q.size() == 0) begin
        mismatched++;
        $display("FAIL rd16_unexpected: cycle %0d rd_en=1, required rd_en=0", cyc);
      end else begin
        mon_ev = rd16_q.pop_front();
        $display("rd16 cycle %0d x=%h y=%h", cyc, x_rd_addr_16, y_rd_addr_16);
        if (mon_ev.cyc != cyc || x_rd_addr_16 !== mon_ev.a0 || y_rd_addr_16 !== mon_ev.a1) begin
          mismatched++;
          $display("FAIL rd16_beat: cycle %0d x=%h y=%h, required cycle %0d x=%h y=%h",
                   cyc, x_rd_addr_16, y_rd_addr_16, mon_ev.cyc, mon_ev.a0, mon_ev.a1);
        end
      end
    end else if (rd16_q.size() != 0 && rd16_q[0].cyc <= cyc) begin
      compared++;
      mismatched++;
      mon_ev = rd16_q.pop_front();
      $display("FAIL rd16_missing: cycle %0d rd_en=0, required rd_en=1 x=%h", cyc, mon_ev.a0);
    end
    // ---- NOE=16 writes ----
    if (wr_en_16) begin
      compared++;
      if (wr16_q.size() == 0) begin
        mismatched++;
        $display("FAIL wr16_unexpected: cycle %0d wr_en=1, required wr_en=0", cyc);
      end else begin
        mon_ev = wr16_q.pop_front();
        $display("wr16 cycle %0d addr=%h mask=%h", cyc, wr_addr_16, wr_mask_16);
        if (mon_ev.cyc != cyc || wr_addr_16 !== mon_ev.a0 || wr_mask_16 !== mon_ev.m) begin
          mismatched++;
          $display("FAIL wr16_beat: cycle %0d addr=%h mask=%h, required cycle %0d addr=%h mask=%h",
                   cyc, wr_addr_16, wr_mask_16, mon_ev.cyc, mon_ev.a0, mon_ev.m);
        end
      end
    end else if (wr16_q.size() != 0 && wr16_q[0].cyc <= cyc) begin
      compared++;
      mismatched++;
      mon_ev = wr16_q.pop_front();
      $display("FAIL wr16_missing: cycle %0d wr_en=0, required wr_en=1 addr=%h", cyc, mon_ev.a0);
    end
  end

  // Drives one start pulse (cycle 0) and queues the expected read/write beats.
  // Chunk i reads in cycle 1+i (shifted past stall_k), writes 9 cycles later.
  // Beats after cycle `cut` are not expected (reset abort).
  task automatic start_pass(input bit use16, input bit op, input logic [63:0] c,
                            input logic [7:0] xb, input logic [7:0] yb, input logic [7:0] rb,
                            input int stall_k, input int cut, output int t0);
    int   nch;
    int   k;
    logic [7:0] lastm;
    ev_t  e;
    nch   = use16 ? 2 : 3;
    lastm = use16 ? 8'hFF : 8'hE0;
    @(posedge clk); #1;
    if (use16) start16 = 1'b1; else start = 1'b1;
    op_in = op; constant_in = c; x_base = xb; y_base = yb; r_base = rb;
    t0 = cyc;
    k  = 1;
    for (int i = 0; i < nch; i++) begin
      if (k == stall_k) k++;
      e.cyc = t0 + k; e.a0 = xb + 8'(i); e.a1 = yb + 8'(i); e.m = 8'h00;
      if (k <= cut) begin
        if (use16) rd16_q.push_back(e); else rd_q.push_back(e);
      end
      e.cyc = t0 + k + 9; e.a0 = rb + 8'(i); e.a1 = 8'h00;
      e.m   = (i == nch - 1) ? lastm : 8'hFF;
      if (k + 9 <= cut) begin
        if (use16) wr16_q.push_back(e); else wr_q.push_back(e);
      end
      k++;
    end
    @(posedge clk); #1;
    start = 1'b0; start16 = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    compared++; if (rd_en !== 1'b0)         begin mismatched++; $display("FAIL reset_rd_en: got %b required 0", rd_en); end
    compared++; if (x_rd_addr !== 8'h00)    begin mismatched++; $display("FAIL reset_x_addr: got %h required 00", x_rd_addr); end
    compared++; if (y_rd_addr !== 8'h00)    begin mismatched++; $display("FAIL reset_y_addr: got %h required 00", y_rd_addr); end
    compared++; if (dp_op !== 1'b0)         begin mismatched++; $display("FAIL reset_dp_op: got %b required 0", dp_op); end
    compared++; if (dp_constant !== 64'h0)  begin mismatched++; $display("FAIL reset_dp_constant: got %h required 0", dp_constant); end
    compared++; if (wr_en !== 1'b0)         begin mismatched++; $display("FAIL reset_wr_en: got %b required 0", wr_en); end
    compared++; if (wr_addr !== 8'h00)      begin mismatched++; $display("FAIL reset_wr_addr: got %h required 00", wr_addr); end
    compared++; if (wr_mask !== 8'h00)      begin mismatched++; $display("FAIL reset_wr_mask: got %h required 00", wr_mask); end
    compared++; if (busy !== 1'b0)          begin mismatched++; $display("FAIL reset_busy: got %b required 0", busy); end
    compared++; if (finish !== 1'b0)        begin mismatched++; $display("FAIL reset_finish: got %b required 0", finish); end
    compared++; if (busy_16 !== 1'b0 || finish_16 !== 1'b0) begin
      mismatched++; $display("FAIL reset_16: busy=%b finish=%b required 0/0", busy_16, finish_16);
    end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_basic();
    int t0;
    start_pass(1'b0, 1'b0, C2, 8'h10, 8'h20, 8'h30, -1, 1000, t0);
    for (int k = 1; k <= 16; k++) begin
      if (k > 1) begin @(posedge clk); #1; end
      @(negedge clk);
      compared++;
      if (busy !== (k <= 12)) begin mismatched++; $display("FAIL basic_busy: cycle %0d got %b required %b", k, busy, (k <= 12)); end
      compared++;
      if (finish !== (k >= 13)) begin mismatched++; $display("FAIL basic_finish: cycle %0d got %b required %b", k, finish, (k >= 13)); end
    end
    compared++;
    if (rd_q.size() != 0 || wr_q.size() != 0) begin
      mismatched++; $display("FAIL basic_drain: pending rd=%0d wr=%0d required 0/0", rd_q.size(), wr_q.size());
    end
  endtask

  task automatic test_op_hold();
    int t0;
    start_pass(1'b0, 1'b1, C15, 8'h40, 8'h50, 8'h60, -1, 1000, t0);
    for (int k = 1; k <= 20; k++) begin
      if (k > 1) begin @(posedge clk); #1; end
      op_in       = ~op_in;
      constant_in = {$urandom, $urandom};
      x_base      = 8'($urandom);
      r_base      = 8'($urandom);
      start       = (k == 5);
      @(negedge clk);
      compared++;
      if (dp_op !== 1'b1) begin mismatched++; $display("FAIL hold_dp_op: cycle %0d got %b required 1", k, dp_op); end
      compared++;
      if (dp_constant !== C15) begin mismatched++; $display("FAIL hold_dp_constant: cycle %0d got %h required %h", k, dp_constant, C15); end
      compared++;
      if (finish !== (k >= 13)) begin mismatched++; $display("FAIL hold_finish: cycle %0d got %b required %b", k, finish, (k >= 13)); end
    end
    start = 1'b0;
    compared++;
    if (rd_q.size() != 0 || wr_q.size() != 0) begin
      mismatched++; $display("FAIL hold_drain: pending rd=%0d wr=%0d required 0/0", rd_q.size(), wr_q.size());
    end
  endtask

  task automatic test_noe16();
    int t0;
    start_pass(1'b1, 1'b0, C2, 8'h00, 8'h08, 8'h10, -1, 1000, t0);
    for (int k = 1; k <= 14; k++) begin
      if (k > 1) begin @(posedge clk); #1; end
      @(negedge clk);
      compared++;
      if (busy_16 !== (k <= 11)) begin mismatched++; $display("FAIL noe16_busy: cycle %0d got %b required %b", k, busy_16, (k <= 11)); end
      compared++;
      if (finish_16 !== (k >= 12)) begin mismatched++; $display("FAIL noe16_finish: cycle %0d got %b required %b", k, finish_16, (k >= 12)); end
    end
    compared++;
    if (rd16_q.size() != 0 || wr16_q.size() != 0) begin
      mismatched++; $display("FAIL noe16_drain: pending rd=%0d wr=%0d required 0/0", rd16_q.size(), wr16_q.size());
    end
  endtask

  task automatic test_reset_midpass();
    int t0;
    start_pass(1'b0, 1'b1, C2, 8'h10, 8'h20, 8'h30, -1, 11, t0);
    for (int k = 1; k <= 16; k++) begin
      if (k > 1) begin @(posedge clk); #1; end
      reset = (k == 11);
      @(negedge clk);
      compared++;
      if (busy !== (k <= 11)) begin mismatched++; $display("FAIL abort_busy: cycle %0d got %b required %b", k, busy, (k <= 11)); end
      compared++;
      if (finish !== 1'b0) begin mismatched++; $display("FAIL abort_finish: cycle %0d got %b required 0", k, finish); end
      if (k >= 12) begin
        compared++;
        if (dp_constant !== 64'h0 || dp_op !== 1'b0) begin
          mismatched++; $display("FAIL abort_dp: cycle %0d op=%b const=%h required 0/0", k, dp_op, dp_constant);
        end
      end
    end
    reset = 1'b0;
    test_basic();
  endtask

  task automatic test_wrap();
    int t0;
    start_pass(1'b0, 1'b0, C2, 8'hFF, 8'h80, 8'hFE, -1, 1000, t0);
    for (int k = 1; k <= 14; k++) begin
      if (k > 1) begin @(posedge clk); #1; end
      @(negedge clk);
      compared++;
      if (finish !== (k >= 13)) begin mismatched++; $display("FAIL wrap_finish: cycle %0d got %b required %b", k, finish, (k >= 13)); end
    end
    compared++;
    if (rd_q.size() != 0 || wr_q.size() != 0) begin
      mismatched++; $display("FAIL wrap_drain: pending rd=%0d wr=%0d required 0/0", rd_q.size(), wr_q.size());
    end
  endtask

`ifdef VXC_SEQ_STALL_EN
  task automatic test_stall();
    int t0;
    start_pass(1'b0, 1'b0, C2, 8'h10, 8'h20, 8'h30, 2, 1000, t0);
    for (int k = 1; k <= 17; k++) begin
      if (k > 1) begin @(posedge clk); #1; end
      stall = (k == 2);
      @(negedge clk);
      compared++;
      if (busy !== (k <= 13)) begin mismatched++; $display("FAIL stall_busy: cycle %0d got %b required %b", k, busy, (k <= 13)); end
      compared++;
      if (finish !== (k >= 14)) begin mismatched++; $display("FAIL stall_finish: cycle %0d got %b required %b", k, finish, (k >= 14)); end
    end
    stall = 1'b0;
    compared++;
    if (rd_q.size() != 0 || wr_q.size() != 0) begin
      mismatched++; $display("FAIL stall_drain: pending rd=%0d wr=%0d required 0/0", rd_q.size(), wr_q.size());
    end
  endtask
`endif

  initial begin
    reset = 1'b1; start = 1'b0; start16 = 1'b0; op_in = 1'b0;
    constant_in = 64'h0; x_base = 8'h00; y_base = 8'h00; r_base = 8'h00;
`ifdef VXC_SEQ_STALL_EN
    stall = 1'b0;
`endif
    test_reset();
    test_basic();
    test_op_hold();
    test_noe16();
    test_reset_midpass();
    test_wrap();
`ifdef VXC_SEQ_STALL_EN
    test_stall();
`endif
    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at 200000, required completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/vxc_chunk_sequencer.md
Name: vxc_chunk_sequencer

Overview:
Controller that runs one full vector-times-constant add/subtract pass, r = y ± c·x, over NOE elements through the NI-lane multiply/delay/adder_subtractor datapath.
- Issues chunked operand reads to the x/y row memories.
- Latches op and constant for the datapath.
- Tracks in-flight chunks across the fixed pipeline latency.
- Generates masked result write-backs and a finish flag.
- Replaces the free-running counter-based finish in the datapath wrapper.

Parameters:
NOE, 19, number of vector elements
NI, 8, lanes per chunk (elements per memory word)
ELEMENT_WIDTH, 64, element width in bits
ADDR_WIDTH, 8, memory word address width
RD_LAT, 1, cycles from rd_en to operand data at datapath inputs
PIPE_LAT, 8, cycles from operands at datapath inputs to valid result

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
start  input  1  request a pass; sampled only when idle
op_in  input  1  0 = add, 1 = subtract; latched on accepted start
constant_in  input  ELEMENT_WIDTH  scalar c; latched on accepted start
x_base  input  ADDR_WIDTH  x row base word address; latched on start
y_base  input  ADDR_WIDTH  y row base word address; latched on start
r_base  input  ADDR_WIDTH  result base word address; latched on start
rd_en  output  1  read strobe to the x and y memories
x_rd_addr  output  ADDR_WIDTH  x word address
y_rd_addr  output  ADDR_WIDTH  y word address
dp_op  output  1  latched op to the datapath
dp_constant  output  ELEMENT_WIDTH  latched constant to the datapath
wr_en  output  1  result word valid; write to the result memory
wr_addr  output  ADDR_WIDTH  result word address
wr_mask  output  NI  per-lane write enable
busy  output  1  pass in progress
finish  output  1  pass complete

Behaviour:
- Chunk count: NCH = ceil(NOE/NI), so NOE=19, NI=8 gives NCH=3.
- Chunk i covers elements NI*i .. NI*i+NI-1.
- Lane layout: element 0 of a chunk sits in the most-significant lane slice. wr_mask bit k enables bits [ELEMENT_WIDTH*(k+1)-1 : ELEMENT_WIDTH*k].
- Reset:
  - All outputs are 0, including dp_constant, dp_op, the addresses and wr_mask.
  - The state is IDLE and the in-flight tracker is cleared.
  - Reset mid-pass aborts immediately. In-flight results are discarded and no wr_en is issued after reset.
- States:
  - IDLE: busy=0. start=1 latches op_in, constant_in and the bases, sets chunk index=0, clears finish, then goes to ISSUE.
  - ISSUE:
    - Each cycle: rd_en=1, x_rd_addr = x_base_l + i, y_rd_addr = y_base_l + i.
    - The chunk index is pushed into a valid/index shift register of depth RD_LAT+PIPE_LAT.
    - i increments. After chunk NCH-1 is issued, go to DRAIN.
  - DRAIN: rd_en=0. When the tracker becomes empty after the last wr_en, go to DONE.
  - DONE: finish=1, busy=0, then go to IDLE with finish held.
  - finish stays 1 until the next accepted start or reset.
- Timing (start accepted at cycle 0):
  - Chunk i: rd_en in cycle 1+i; wr_en in cycle 1+i+RD_LAT+PIPE_LAT.
  - finish rises the cycle after the last wr_en.
  - busy is 1 from cycle 1 through the last wr_en cycle.
- Write-back:
  - wr_addr = r_base_l + i.
  - wr_mask = all ones, except for the last chunk when NOE%NI != 0: top NOE%NI bits set. For 19/8 this gives 8'b1110_0000.
- Address arithmetic is modulo 2^ADDR_WIDTH (wraps silently).
- dp_op and dp_constant are held constant from accept until the next accepted start. Changes on op_in, constant_in or the bases during a pass are ignored.
- start while busy or in DRAIN is ignored and not queued.
- start in the same cycle as reset: reset wins.

Optional Feature:
- Macro VXC_SEQ_STALL_EN.
- Defined:
  - Adds input port stall (1 bit).
  - In ISSUE, stall=1 forces rd_en=0 and holds the chunk index; nothing is pushed into the tracker.
  - In-flight chunks continue to drain and write on schedule, because the datapath has no enable.
  - stall has no effect in other states.
- Undefined: the stall port is absent and issue is back-to-back.

Test Plan:
1. Reset; start with op_in=0, const=2.0, x_base=0x10, y_base=0x20, r_base=0x30.
   -> rd_en in cycles 1-3 at x addresses 0x10/0x11/0x12 and y addresses 0x20/0x21/0x22.
   -> wr_en in cycles 10-12 at 0x30/0x31/0x32 with masks FF/FF/E0.
   -> finish rises at cycle 13; busy is low at 13.
2. Start with op_in=1, then toggle op_in and constant_in during the pass -> dp_op=1 and dp_constant unchanged throughout; a start pulse at cycle 5 is ignored (no second pass).
3. Build with NOE=16 -> 2 chunks, both masks FF, finish at cycle 12.
4. Assert reset at cycle 11 of test 1 -> wr_en 0 from cycle 12 on, busy=0, finish=0; a new start completes normally.
5. x_base=0xFF, r_base=0xFE -> read addresses 0xFF, 0x00, 0x01; write addresses 0xFE, 0xFF, 0x00.
6. VXC_SEQ_STALL_EN build, stall=1 in cycle 2 only -> rd_en in cycles 1, 3, 4; wr_en in cycles 10, 12, 13; finish at cycle 14.
